// File: rtl/u_div.sv
// u_div: multi-cycle unsigned restoring divider.
//
// Each division takes a fixed WIDTH+1 cycles from the start strobe to the
// done pulse, for every operand pair including a zero divisor. This lets
// the issue logic schedule writeback without waiting on a handshake.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   start        request strobe, sampled only while busy=0
//   dividend     unsigned dividend, sampled with start
//   divisor      unsigned divisor, sampled with start
//   busy         high while a division is in progress
//   done         one-cycle pulse; results are valid from this cycle onward
//   quotient     unsigned quotient, held until the next completion
//   remainder    unsigned remainder, held until the next completion
//   div_by_zero  divisor was zero for the completed operation
module u_div #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] CALC = 1'b1;

  logic [0:0]       state;
  logic [CW-1:0]    cnt;
  // Dividend bits leave from the top while quotient bits enter at the
  // bottom, so one register serves as both dividend and quotient shifter.
  logic [WIDTH-1:0] dq_sr;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH:0]   rem;
  logic             dbz_next;

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] diff;
  logic             borrow;
  logic [WIDTH:0]   next_rem;
  logic [WIDTH-1:0] next_dq;

  // One restoring step: bring in the next dividend bit and try to subtract
  // the divisor. The top bit of the difference is the borrow.
  always_comb begin
    shifted  = {rem, dq_sr[WIDTH-1]};
    diff     = shifted - {2'b00, dvs};
    borrow   = diff[WIDTH+1];
    next_rem = borrow ? shifted[WIDTH:0] : diff[WIDTH:0];
    next_dq  = {dq_sr[WIDTH-2:0], ~borrow};
  end

  assign busy = (state == CALC);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      dq_sr       <= '0;
      dvs         <= '0;
      rem         <= '0;
      dbz_next    <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            dq_sr    <= dividend;
            dvs      <= divisor;
            rem      <= '0;
            cnt      <= CNT_LOAD;
            dbz_next <= (divisor == '0);
            state    <= CALC;
          end
        end
        CALC: begin
          rem   <= next_rem;
          dq_sr <= next_dq;
          cnt   <= cnt - 1'b1;
          // The last step publishes results straight from the step logic so
          // done appears in the following cycle with values already stable.
          if (cnt == '0) begin
            quotient    <= next_dq;
            remainder   <= next_rem[WIDTH-1:0];
            div_by_zero <= dbz_next;
            done        <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
